// File: rtl/fft_window_buffer_if.sv
// Sample-in / window-out stream bundle for fft_window_buffer.
// slave is the buffer's view; master is the front end / FFT side.
interface fft_window_buffer_if #(
    parameter int NCH   = 2,
    parameter int W     = 22,
    parameter int DEPTH = 1024
) ();
    logic                     in_valid;
    logic [NCH*W-1:0]         in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [NCH*W-1:0]         out_data;
    logic [$clog2(DEPTH)-1:0] out_index;
    logic                     out_first;
    logic                     out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_index, out_first, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_index, out_first, out_last
    );
endinterface

// File: rtl/fft_window_buffer.sv
// Multi-channel sliding-window buffer: circular store of 2*DEPTH sample sets,
// streams a DEPTH-long window (oldest first) after fill and every HOP samples.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_FILL | store not yet holding DEPTH samples; waiting for first trigger
// S_IDLE | no active frame; waiting for the next hop trigger
// S_RD   | synchronous read of window sample base+idx in flight
// S_HOLD | out_valid high, waiting for out_ready
module fft_window_buffer #(
    parameter int NCH   = 2,
    parameter int W     = 22,
    parameter int DEPTH = 1024,
    parameter int HOP   = 128
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    fft_window_buffer_if.slave  bus,
    output logic                fill_done,
    output logic                frame_abort,
    output logic                overrun,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = AW + 2;
    localparam int HW = (HOP > 1) ? $clog2(HOP) : 1;
    localparam int DW = NCH * W;

    typedef enum logic [1:0] {S_FILL, S_IDLE, S_RD, S_HOLD} state_t;

    state_t          state, state_next;
    logic [DW-1:0]   mem [0:2*DEPTH-1];
    logic [DW-1:0]   rd_data;
    logic [PW-1:0]   wp, sc, trig_base, base;
    logic [HW-1:0]   hc;
    logic [AW-1:0]   idx;
    logic [KW-1:0]   k;
    logic            trig_q;

    logic            wr, fill_hit, hop_hit, trigger, busy, abort;
    logic            accept, last, launch, drop;
    logic [PW-1:0]   wp_inc;
    logic [KW-1:0]   k_inc;

    always_comb begin
        wr       = bus.in_valid & ~clear;
        wp_inc   = wp + PW'(1);
        k_inc    = k + KW'(1);
        fill_hit = (sc == PW'(DEPTH - 1));
        hop_hit  = (sc == PW'(DEPTH)) && (hc == HW'(HOP - 1));
        trigger  = wr && (fill_hit || hop_hit);
        busy     = (state == S_RD) || (state == S_HOLD);
        last     = (idx == AW'(DEPTH - 1));
        accept   = (state == S_HOLD) && bus.out_ready;
        launch   = trig_q && !busy;
        drop     = trig_q && busy;
        // Next write would land on a slot the frame has not yet read.
        abort    = busy && wr && (k_inc >= (KW'(DEPTH) + KW'(idx)));
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FILL, S_IDLE: if (trig_q) state_next = S_RD;
            S_RD:           state_next = S_HOLD;
            S_HOLD:         if (accept) state_next = last ? S_IDLE : S_RD;
            default:        state_next = S_FILL;
        endcase
        if (abort) state_next = S_IDLE;
        if (clear) state_next = S_FILL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FILL;
        else          state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp          <= '0;
            sc          <= '0;
            hc          <= '0;
            idx         <= '0;
            k           <= '0;
            base        <= '0;
            trig_base   <= '0;
            trig_q      <= 1'b0;
            rd_data     <= '0;
            fill_done   <= 1'b0;
            frame_abort <= 1'b0;
            overrun     <= 1'b0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
        end else if (clear) begin
            wp          <= '0;
            sc          <= '0;
            hc          <= '0;
            idx         <= '0;
            k           <= '0;
            trig_q      <= 1'b0;
            fill_done   <= 1'b0;
            frame_abort <= 1'b0;
            overrun     <= 1'b0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
        end else begin
            frame_abort <= abort;
            trig_q      <= trigger;
            if (trigger) trig_base <= wp_inc - PW'(DEPTH);

            if (wr) begin
                wp <= wp_inc;
                if (sc != PW'(DEPTH)) sc <= sc + PW'(1);
                else                  hc <= (hc == HW'(HOP - 1)) ? '0 : hc + HW'(1);
                if (fill_hit) fill_done <= 1'b1;
            end

            // The trigger write itself is write zero of the new frame.
            if (launch) begin
                base <= trig_base;
                idx  <= '0;
                k    <= wr ? KW'(1) : '0;
            end else if (busy && wr) begin
                k <= k_inc;
            end

            if (state == S_RD) rd_data <= mem[base + PW'(idx)];

            if (accept && !abort) begin
                if (!last)                      idx       <= idx + AW'(1);
                else if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            end

            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (drop || abort)                overrun  <= 1'b1;
        end
    end

    assign bus.out_valid = (state == S_HOLD);
    assign bus.out_data  = rd_data;
    assign bus.out_index = idx;
    assign bus.out_first = (state == S_HOLD) && (idx == '0);
    assign bus.out_last  = (state == S_HOLD) && last;
endmodule

// File: tb/tb_fft_window_buffer.sv
// Directed bench for fft_window_buffer with DEPTH=8, HOP=4, NCH=2.
// Channel 1 always carries channel 0 value plus 100.
module tb_fft_window_buffer;
    localparam int NCH   = 2;
    localparam int W     = 22;
    localparam int DEPTH = 8;
    localparam int HOP   = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        fill_done;
    logic        frame_abort;
    logic        overrun;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    fft_window_buffer_if #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) bus ();

    fft_window_buffer #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .HOP(HOP)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .bus         (bus),
        .fill_done   (fill_done),
        .frame_abort (frame_abort),
        .overrun     (overrun),
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int n);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = n[W-1:0];
        b = W'(n + 100);
        bus.in_data  = {b, a};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("valid_wait", 32'(bus.out_valid), 1);
    endtask

    task automatic expect_sample(input int i, input int d0);
        wait_valid();
        check($sformatf("index[%0d]", i), 32'(bus.out_index), i);
        check($sformatf("ch0[%0d]", i), 32'(bus.out_data[W-1:0]), d0);
        check($sformatf("ch1[%0d]", i), 32'(bus.out_data[2*W-1:W]), d0 + 100);
        check($sformatf("first[%0d]", i), 32'(bus.out_first), (i == 0) ? 1 : 0);
        check($sformatf("last[%0d]", i), 32'(bus.out_last), (i == DEPTH - 1) ? 1 : 0);
        tick();
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_valid"}, 32'(bus.out_valid), 0);
        check({pfx, "_data"}, 32'(bus.out_data[W-1:0]), 0);
        check({pfx, "_index"}, 32'(bus.out_index), 0);
        check({pfx, "_first"}, 32'(bus.out_first), 0);
        check({pfx, "_last"}, 32'(bus.out_last), 0);
        check({pfx, "_fill"}, 32'(fill_done), 0);
        check({pfx, "_abort"}, 32'(frame_abort), 0);
        check({pfx, "_overrun"}, 32'(overrun), 0);
        check({pfx, "_frame_cnt"}, 32'(frame_cnt), 0);
        check({pfx, "_drop_cnt"}, 32'(drop_cnt), 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        check_reset_values("rst");
        reset_n = 1'b1;
        tick();

        // First fill and first frame: ch0 = 0..7
        bus.out_ready = 1'b1;
        for (int n = 0; n < 7; n++) wr(n);
        check("fill_before", 32'(fill_done), 0);
        wr(7);
        check("fill_after", 32'(fill_done), 1);
        check("lat_t0", 32'(bus.out_valid), 0);
        tick();
        check("lat_t1", 32'(bus.out_valid), 0);
        tick();
        check("lat_t2", 32'(bus.out_valid), 1);
        for (int i = 0; i < DEPTH; i++) expect_sample(i, i);
        check("frame_cnt_1", 32'(frame_cnt), 1);
        check("idle_valid_1", 32'(bus.out_valid), 0);

        // Hop of 4: ch0 = 4..11
        for (int n = 8; n < 12; n++) wr(n);
        for (int i = 0; i < DEPTH; i++) expect_sample(i, 4 + i);
        check("frame_cnt_2", 32'(frame_cnt), 2);
        check("overrun_clean", 32'(overrun), 0);

        // Stall at index 0 while 4 writes produce a dropped trigger
        bus.out_ready = 1'b0;
        for (int n = 12; n < 16; n++) wr(n);
        wait_valid();
        check("stall_ch0", 32'(bus.out_data[W-1:0]), 8);
        for (int j = 0; j < 4; j++) begin
            wr(16 + j);
            check($sformatf("stall_valid[%0d]", j), 32'(bus.out_valid), 1);
            check($sformatf("stall_data[%0d]", j), 32'(bus.out_data[W-1:0]), 8);
            check($sformatf("stall_index[%0d]", j), 32'(bus.out_index), 0);
        end
        tick();
        check("drop_cnt_1", 32'(drop_cnt), 1);
        check("overrun_drop", 32'(overrun), 1);
        check("stall_data_end", 32'(bus.out_data[2*W-1:W]), 108);
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) expect_sample(i, 8 + i);
        check("frame_cnt_3", 32'(frame_cnt), 3);

        // Stall at index 0 through 8 writes: abort on the 8th
        bus.out_ready = 1'b0;
        for (int n = 20; n < 24; n++) wr(n);
        wait_valid();
        check("abort_ch0", 32'(bus.out_data[W-1:0]), 16);
        for (int j = 0; j < 8; j++) begin
            wr(24 + j);
            if (j < 7) begin
                check($sformatf("pre_abort_pulse[%0d]", j), 32'(frame_abort), 0);
                check($sformatf("pre_abort_valid[%0d]", j), 32'(bus.out_valid), 1);
            end else begin
                check("abort_pulse", 32'(frame_abort), 1);
                check("abort_valid", 32'(bus.out_valid), 0);
                check("abort_overrun", 32'(overrun), 1);
            end
        end
        tick();
        check("abort_pulse_end", 32'(frame_abort), 0);
        check("abort_frame_cnt", 32'(frame_cnt), 3);
        check("abort_drop_cnt", 32'(drop_cnt), 2);

        // The trigger on the aborting write launches ch0 = 24..31; clear it mid-frame
        wait_valid();
        check("relaunch_ch0", 32'(bus.out_data[W-1:0]), 24);
        clear        = 1'b1;
        bus.in_data  = 44'd99;
        bus.in_valid = 1'b1;
        tick();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_valid", 32'(bus.out_valid), 0);
        check("clr_abort", 32'(frame_abort), 0);
        check("clr_frame_cnt", 32'(frame_cnt), 0);
        check("clr_drop_cnt", 32'(drop_cnt), 0);
        check("clr_overrun", 32'(overrun), 0);
        check("clr_fill", 32'(fill_done), 0);
        bus.out_ready = 1'b1;
        for (int n = 200; n < 207; n++) wr(n);
        repeat (3) tick();
        check("refill_valid", 32'(bus.out_valid), 0);
        check("refill_fill", 32'(fill_done), 0);
        wr(207);
        check("refill_done", 32'(fill_done), 1);
        for (int i = 0; i < DEPTH; i++) expect_sample(i, 200 + i);
        check("refill_frame_cnt", 32'(frame_cnt), 1);

        // Asynchronous reset while holding index 1 of ch0 = 204..211
        bus.out_ready = 1'b0;
        for (int n = 208; n < 212; n++) wr(n);
        wait_valid();
        check("pre_rst_ch0", 32'(bus.out_data[W-1:0]), 204);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        wait_valid();
        check("pre_rst_index", 32'(bus.out_index), 1);
        check("pre_rst_ch1", 32'(bus.out_data[2*W-1:W]), 305);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("arst");
        #10;
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_window_buffer.md
# fft_window_buffer

Parametrised multi-channel sliding-window sample buffer between the sample front end and the FFT cores. It captures one sample per channel per `in_valid` into a circular store of 2×DEPTH entries. After the initial fill, and every HOP samples after that, it streams one DEPTH-sample window (oldest first, all channels in parallel) to the FFT input over a valid/ready handshake. It counts emitted and dropped frames and flags overruns.

## Interface
- `NCH`, 2, channel count (LED1/LED2 = 2)
- `W`, 22, sample width per channel, bits
- `DEPTH`, 1024, window length; power of two, ≥4
- `HOP`, 128, new samples between window launches; 1 ≤ HOP ≤ DEPTH
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous flush: returns to FILL and zeroes counters
- `in_valid`  in  1  one new sample set present on `in_data`
- `in_data`  in  NCH×W  channel c at bits [c×W +: W]
- `out_valid`  out  1  `out_data` holds a window sample
- `out_ready`  in  1  FFT accepts the current sample
- `out_data`  out  NCH×W  window sample, same packing as `in_data`
- `out_index`  out  log2(DEPTH)  position in window, 0 = oldest
- `out_first` / `out_last`  out  1  qualify index 0 / index DEPTH−1
- `fill_done`  out  1  high once the first DEPTH samples are stored
- `frame_abort`  out  1  one-cycle pulse; the active frame was cut short
- `overrun`  out  1  sticky; set on a drop or an abort
- `frame_cnt`, `drop_cnt`  out  16 each  completed frames and dropped triggers, saturating

## Operation
- Storage: per-channel circular memory of 2×DEPTH words with synchronous read. The write pointer `wp` increments modulo 2×DEPTH on every accepted `in_valid`, in every state. `in_valid` is never back-pressured.
- Sample counter `sc`: counts writes up to DEPTH, and `fill_done` rises at that point. After that, hop counter `hc` counts writes modulo HOP.
- Trigger: the write that brings `sc` to DEPTH, and every later write that brings `hc` to 0. On a trigger, the window base `base = wp_new − DEPTH` (modulo 2×DEPTH, where `wp_new` is the pointer after this write) and the window includes the sample just written.
- States:
  - FILL: wait for the first trigger, then go to RD.
  - IDLE: wait for a trigger, then go to RD.
  - RD: issue a read of `base + idx`, then go to HOLD.
  - HOLD: `out_valid` = 1. When `out_ready` is high: if `idx` = DEPTH−1, go to IDLE and increment `frame_cnt`; otherwise increment `idx` and go to RD.
- A trigger in RD or HOLD is dropped: increment `drop_cnt`, set `overrun`. The active frame continues.
- Abort: while RD or HOLD, the k-th write since launch (k ≥ DEPTH) with `idx` ≤ k−DEPTH would overwrite unread data. In that case, drop `out_valid` the next cycle, pulse `frame_abort`, set `overrun`, go to IDLE, and do not increment `frame_cnt`.
- `clear` (and reset) set `wp`/`sc`/`hc`/`idx` = 0, all counters = 0, `overrun` = 0, `fill_done` = 0, and state = FILL. The store contents are not erased. If `clear` and `in_valid` arrive in the same cycle, `clear` wins and the sample is discarded. `clear` mid-frame drops `out_valid` with no `frame_abort` pulse.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_index` = 0, `out_first` = 0, `out_last` = 0, `fill_done` = 0, `frame_abort` = 0, `overrun` = 0, `frame_cnt` = 0, `drop_cnt` = 0.
- Launch latency: trigger write at edge t → RD at t+1 → `out_valid` high after edge t+2.
- Throughput: at most one sample per 2 cycles. A full frame takes at least 2×DEPTH cycles.
- While `out_valid` is high without `out_ready`, `out_data`, `out_index`, `out_first` and `out_last` hold stable.
- `out_first`/`out_last` are valid only while `out_valid` is high, otherwise 0.
- `fill_done`, the counters and `overrun` update on the edge after the causing event.

## Test plan
- DEPTH=8, HOP=4, NCH=2. Write ch0 = n, ch1 = 100+n for n = 0..7 with `out_ready` = 1 → one frame with ch0 = 0..7, `out_first` at index 0, `out_last` at 7, `frame_cnt` = 1, `fill_done` rises after n = 7.
- Continue with n = 8..11 after the frame completes → second frame with ch0 = 4..11, `frame_cnt` = 2.
- Hold `out_ready` = 0 during a frame while writing 4 more samples → `drop_cnt` = 1, `overrun` = 1, and `out_data` stays stable throughout.
- Hold `out_ready` = 0 at index 0 while writing 8 more samples → `frame_abort` pulses on the 8th write, `out_valid` drops, `frame_cnt` is unchanged.
- Assert `clear` together with `in_valid` mid-frame → `out_valid` = 0 next cycle, all counters = 0, the sample is discarded, and the next frame needs 8 fresh samples.
- Assert `reset_n` low asynchronously mid-HOLD → all outputs take their reset values immediately, before the next clock edge.
